shift_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter for the CORDIC datapath; replaces the fixed 32-bit shift-by-one unit.

---
 rtl/shift_pkg.sv | 11 +
 rtl/shift_stage.sv | 72 +++++++
 rtl/shift_pipe.sv | 76 +++++++
 tb/tb_shift_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shift mode encoding shared by the barrel shifter pipeline
package shift_pkg;

   typedef enum logic [1:0] {
      MODE_LSR = 2'b00,
      MODE_LSL = 2'b01,
      MODE_ASR = 2'b10,
      MODE_ROR = 2'b11
   } shift_mode_t;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one registered barrel-shifter stage: conditional shift by DIST with valid/ready
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1,
   parameter int SHW   = 5,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  shift_mode_t      in_mode,
   input  logic             in_ovf,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SHW-1:0]   out_amt,
   output shift_mode_t      out_mode,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   logic [WIDTH-1:0] shifted;
   logic             lost;

   // in_amt[0] is this stage's bit; the carried amount is shifted down so the next stage sees its bit at [0]
   always_comb begin
      shifted = in_data;
      lost    = 1'b0;
      if (in_amt[0]) begin
         case (in_mode)
            MODE_LSR: shifted = in_data >> DIST;
            MODE_LSL: begin
               shifted = in_data << DIST;
               lost    = |in_data[WIDTH-1 -: DIST];
            end
            // MSB of an ASR operand stays equal to the sign captured at acceptance
            MODE_ASR: shifted = {{DIST{in_data[WIDTH-1]}}, in_data[WIDTH-1:DIST]};
            MODE_ROR: shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
            default:  shifted = in_data;
         endcase
      end
   end

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_amt   <= '0;
         out_mode  <= MODE_LSR;
         out_ovf   <= 1'b0;
         out_tag   <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= shifted;
         out_amt   <= in_amt >> 1;
         out_mode  <= in_mode;
         out_ovf   <= in_ovf | lost;
         out_tag   <= in_tag;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter (LSR/LSL/ASR/ROR), one stage per shift-amount bit
module shift_pipe
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH),
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   // Index k is the input side of stage k; index SHW is the pipe output
   logic             v    [0:SHW];
   logic             r    [0:SHW];
   logic [WIDTH-1:0] d    [0:SHW];
   logic [SHW-1:0]   amt  [0:SHW];
   shift_mode_t      mode [0:SHW];
   logic             ovf  [0:SHW];
   logic [TAG_W-1:0] tag  [0:SHW];

   assign v[0]    = in_valid;
   assign d[0]    = in_data;
   assign amt[0]  = in_amt;
   assign mode[0] = shift_mode_t'(in_mode);
   assign ovf[0]  = 1'b0;
   assign tag[0]  = in_tag;
   assign r[SHW]  = out_ready;

   genvar k;
   generate
      for (k = 0; k < SHW; k++) begin : g_stage
         shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k),
            .SHW   (SHW),
            .TAG_W (TAG_W)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v[k]),
            .in_ready  (r[k]),
            .in_data   (d[k]),
            .in_amt    (amt[k]),
            .in_mode   (mode[k]),
            .in_ovf    (ovf[k]),
            .in_tag    (tag[k]),
            .out_valid (v[k+1]),
            .out_ready (r[k+1]),
            .out_data  (d[k+1]),
            .out_amt   (amt[k+1]),
            .out_mode  (mode[k+1]),
            .out_ovf   (ovf[k+1]),
            .out_tag   (tag[k+1])
         );
      end
   endgenerate

   assign in_ready  = r[0];
   assign out_valid = v[SHW];
   assign out_data  = d[SHW];
   assign out_ovf   = ovf[SHW];
   assign out_tag   = tag[SHW];

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - self-checking bench for shift_pipe with directed vectors and a random stream
module tb_shift_pipe;

   localparam int WIDTH = 32;
   localparam int SHW   = 5;
   localparam int TAG_W = 4;
   localparam int NBEAT = 40;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   logic [1:0]       in_mode;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;
   logic [TAG_W-1:0] out_tag;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             ovf;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];

   shift_pipe #(.WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: whole-word shift by the full amount, mode by mode
   function automatic exp_t ref_shift(input logic [31:0] d, input int a, input logic [1:0] m,
                                      input logic [TAG_W-1:0] t);
      exp_t        e;
      logic [63:0] w;
      e.ovf = 1'b0;
      e.tag = t;
      case (m)
         2'b00: e.d = d >> a;
         2'b01: begin
            w     = {32'b0, d} << a;
            e.d   = w[31:0];
            e.ovf = (w[63:32] != 32'b0);
         end
         2'b10: e.d = $signed(d) >>> a;
         default: begin
            w   = {d, d} >> a;
            e.d = w[31:0];
         end
      endcase
      return e;
   endfunction

   task automatic directed(input string name, input logic [31:0] d, input logic [4:0] a,
                           input logic [1:0] m, input logic [3:0] t,
                           input logic [31:0] exp_d, input logic exp_ovf);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_mode  = m;
      in_tag   = t;
      #1;
      check({name, "_in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check({name, "_latency"}, 64'(n), 64'd5);
      check({name, "_data"}, 64'(out_data), 64'(exp_d));
      check({name, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
      check({name, "_tag"}, 64'(out_tag), 64'(t));
      tick();
   endtask

   logic [31:0]      s_d   [NBEAT];
   logic [4:0]       s_a   [NBEAT];
   logic [1:0]       s_m   [NBEAT];
   logic [TAG_W-1:0] s_t   [NBEAT];

   initial begin
      int               sent, recvd, cyc, seen;
      logic             stalled;
      logic [31:0]      p_d;
      logic             p_ovf;
      logic [TAG_W-1:0] p_tag;
      exp_t             e;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; in_tag = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_ovf", 64'(out_ovf), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      directed("lsr1", 32'hAAAAAAAA, 5'd1, 2'b00, 4'h1, 32'h55555555, 1'b0);
      directed("lsl1", 32'hAAAAAAAA, 5'd1, 2'b01, 4'h2, 32'h55555554, 1'b1);
      directed("lsl1_small", 32'h00000005, 5'd1, 2'b01, 4'h3, 32'h0000000A, 1'b0);
      directed("asr4", 32'h80000000, 5'd4, 2'b10, 4'h4, 32'hF8000000, 1'b0);
      directed("lsr1_msb", 32'h80000000, 5'd1, 2'b00, 4'h5, 32'h40000000, 1'b0);
      directed("asr31", 32'h7FFFFFFF, 5'd31, 2'b10, 4'h6, 32'h00000000, 1'b0);
      directed("ror8", 32'h12345678, 5'd8, 2'b11, 4'hA, 32'h78123456, 1'b0);
      directed("ror0", 32'h12345678, 5'd0, 2'b11, 4'h7, 32'h12345678, 1'b0);
      directed("lsl0", 32'hFFFFFFFF, 5'd0, 2'b01, 4'h8, 32'hFFFFFFFF, 1'b0);

      // Random stream with pseudo-random backpressure and a forced stall window
      for (int i = 0; i < NBEAT; i++) begin
         s_d[i] = $urandom;
         s_a[i] = 5'($urandom_range(0, 31));
         s_m[i] = 2'($urandom_range(0, 3));
         s_t[i] = 4'($urandom_range(0, 15));
      end
      sent = 0; recvd = 0; cyc = 0; stalled = 1'b0;
      p_d = '0; p_ovf = 1'b0; p_tag = '0;
      while ((sent < NBEAT || recvd < NBEAT) && cyc < 600) begin
         in_valid  = (sent < NBEAT) && ($urandom_range(0, 3) != 0);
         if (sent < NBEAT) begin
            in_data = s_d[sent]; in_amt = s_a[sent]; in_mode = s_m[sent]; in_tag = s_t[sent];
         end
         out_ready = (cyc >= 8 && cyc < 18) ? 1'b0 : 1'($urandom_range(0, 1));
         #1;
         check("str_in_ready", 64'(in_ready), 64'(!(exp_q.size() == SHW && !out_ready)));
         if (exp_q.size() == 0) check("str_idle_valid", 64'(out_valid), 64'd0);
         if (stalled) begin
            check("str_hold_valid", 64'(out_valid), 64'd1);
            check("str_hold_data", 64'(out_data), 64'(p_d));
            check("str_hold_ovf", 64'(out_ovf), 64'(p_ovf));
            check("str_hold_tag", 64'(out_tag), 64'(p_tag));
         end
         if (out_valid && out_ready) begin
            check("str_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("str_data", 64'(out_data), 64'(e.d));
               check("str_ovf", 64'(out_ovf), 64'(e.ovf));
               check("str_tag", 64'(out_tag), 64'(e.tag));
            end
            recvd++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_shift(in_data, int'(in_amt), in_mode, in_tag));
            sent++;
         end
         stalled = out_valid && !out_ready;
         p_d = out_data; p_ovf = out_ovf; p_tag = out_tag;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("str_all_received", 64'(recvd), 64'(NBEAT));
      check("str_queue_empty", 64'(exp_q.size()), 64'd0);
      tick();
      check("str_drained", 64'(out_valid), 64'd0);

      // Reset with three beats in flight
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h1000 + 32'(i);
         in_amt   = 5'd0;
         in_mode  = 2'b00;
         in_tag   = 4'(i);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("midrst_no_emerge", 64'(seen), 64'd0);
      directed("post_rst", 32'hC0000001, 5'd2, 2'b11, 4'h9, 32'h70000000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
